// File: rtl/core_l1d_resp_if.sv
// L1D request/acknowledge bundle between the pipeline memory stage (master)
// and the data-side responder (slave).
interface core_l1d_resp_if;
    logic        l1d_req_val;
    logic [31:0] l1d_req_addr;
    logic [2:0]  l1d_req_cop;
    logic [31:0] l1d_req_wdata;
    logic [2:0]  l1d_req_size;
    logic        l1d_ack_ack;
    logic [31:0] l1d_ack_rdata;

    modport master (
        output l1d_req_val,
        output l1d_req_addr,
        output l1d_req_cop,
        output l1d_req_wdata,
        output l1d_req_size,
        input  l1d_ack_ack,
        input  l1d_ack_rdata
    );

    modport slave (
        input  l1d_req_val,
        input  l1d_req_addr,
        input  l1d_req_cop,
        input  l1d_req_wdata,
        input  l1d_req_size,
        output l1d_ack_ack,
        output l1d_ack_rdata
    );
endinterface

// File: rtl/core_l1d_resp.sv
// Data-side L1D responder: one load/store at a time on an internal word SRAM,
// acknowledged after a fixed programmable latency.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for l1d_req_val; request fields latched on accept
// ST_WAIT  | latency countdown, request inputs ignored
// ST_ACK   | one-cycle ack; write commits at the edge ending this state
module core_l1d_resp #(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    core_l1d_resp_if.slave        l1d,
    output logic                  busy,
    output logic                  err_misalign,
    output logic                  err_range
);

    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [3:0]  CNT_LOAD   = 4'(LATENCY - 1);
    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic [AW+1:0] lat_addr;
    logic [31:0]   lat_wdata;
    logic [1:0]    lat_size;
    logic          lat_write;
    logic          lat_bad;

    logic [1:0]    req_size;
    logic          req_write;
    logic          req_mis;
    logic          req_rng;

    logic [31:0]   mem [MEM_WORDS];
    logic [AW-1:0] word_idx;
    logic [31:0]   mem_word;
    logic [31:0]   wmask;
    logic [31:0]   wlanes;
    logic [31:0]   rd_word;

    // Request decode; unknown size codes act as word, unknown cops as read.
    always_comb begin
        req_size = SZ_WORD;
        case (l1d.l1d_req_size)
            3'b000:  req_size = SZ_BYTE;
            3'b001:  req_size = SZ_HALF;
            default: req_size = SZ_WORD;
        endcase
        req_write = (l1d.l1d_req_cop == 3'b001);
        req_mis   = ((req_size == SZ_HALF) && l1d.l1d_req_addr[0]) ||
                    ((req_size == SZ_WORD) && (l1d.l1d_req_addr[1:0] != 2'b00));
        req_rng   = ({1'b0, l1d.l1d_req_addr} >= ADDR_LIMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_size     <= SZ_WORD;
            lat_write    <= 1'b0;
            lat_bad      <= 1'b0;
            err_misalign <= 1'b0;
            err_range    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (l1d.l1d_req_val) begin
                        lat_addr     <= l1d.l1d_req_addr[AW+1:0];
                        lat_wdata    <= l1d.l1d_req_wdata;
                        lat_size     <= req_size;
                        lat_write    <= req_write;
                        lat_bad      <= req_mis | req_rng;
                        err_misalign <= err_misalign | req_mis;
                        err_range    <= err_range | req_rng;
                        cnt          <= CNT_LOAD;
                        state        <= (CNT_LOAD == 4'd0) ? ST_ACK : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd1) begin
                        state <= ST_ACK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_ACK:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign word_idx = lat_addr[AW+1:2];
    assign mem_word = mem[word_idx];

    always_comb begin
        wmask  = 32'hFFFF_FFFF;
        wlanes = lat_wdata;
        case (lat_size)
            SZ_BYTE: begin
                wmask  = 32'h0000_00FF << {lat_addr[1:0], 3'b000};
                wlanes = {4{lat_wdata[7:0]}};
            end
            SZ_HALF: begin
                wmask  = 32'h0000_FFFF << {lat_addr[1], 4'b0000};
                wlanes = {2{lat_wdata[15:0]}};
            end
            default: begin
                wmask  = 32'hFFFF_FFFF;
                wlanes = lat_wdata;
            end
        endcase
    end

    // SRAM contents are deliberately not reset; async reset drops a pending write
    // because state has already left ST_ACK by the next edge.
    always_ff @(posedge clk) begin
        if ((state == ST_ACK) && lat_write && !lat_bad) begin
            mem[word_idx] <= (mem_word & ~wmask) | (wlanes & wmask);
        end
    end

    always_comb begin
        rd_word = mem_word;
        case (lat_size)
            SZ_BYTE: rd_word = (mem_word >> {lat_addr[1:0], 3'b000}) & 32'h0000_00FF;
            SZ_HALF: rd_word = (mem_word >> {lat_addr[1], 4'b0000}) & 32'h0000_FFFF;
            default: rd_word = mem_word;
        endcase
    end

    assign l1d.l1d_ack_ack   = (state == ST_ACK);
    assign l1d.l1d_ack_rdata = ((state == ST_ACK) && !lat_write && !lat_bad) ? rd_word : 32'h0;
    assign busy              = (state != ST_IDLE);

endmodule

// File: tb/tb_core_l1d_resp.sv
// Directed bench for core_l1d_resp: a LATENCY=2 instance for functional and
// error-flag checks and a LATENCY=1 instance for back-to-back and reset cases.
module tb_core_l1d_resp;

    localparam logic [2:0] OP_RD = 3'b000;
    localparam logic [2:0] OP_WR = 3'b001;
    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;

    logic clk;
    logic rst0_n;
    logic rst1_n;
    logic busy0, mis0, rng0;
    logic busy1, mis1, rng1;

    int n_tests = 0;
    int n_fail  = 0;

    core_l1d_resp_if bus0 ();
    core_l1d_resp_if bus1 ();

    core_l1d_resp #(.MEM_WORDS(1024), .LATENCY(2)) u_dut0 (
        .clk          (clk),
        .rst_n        (rst0_n),
        .l1d          (bus0.slave),
        .busy         (busy0),
        .err_misalign (mis0),
        .err_range    (rng0)
    );

    core_l1d_resp #(.MEM_WORDS(1024), .LATENCY(1)) u_dut1 (
        .clk          (clk),
        .rst_n        (rst1_n),
        .l1d          (bus1.slave),
        .busy         (busy1),
        .err_misalign (mis1),
        .err_range    (rng1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ack(input int d);
        return (d == 0) ? bus0.l1d_ack_ack : bus1.l1d_ack_ack;
    endfunction

    function automatic logic [31:0] get_rdata(input int d);
        return (d == 0) ? bus0.l1d_ack_rdata : bus1.l1d_ack_rdata;
    endfunction

    function automatic logic get_busy(input int d);
        return (d == 0) ? busy0 : busy1;
    endfunction

    task automatic drive(input int d, input logic v, input logic [2:0] cop, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (d == 0) begin
            bus0.l1d_req_val = v; bus0.l1d_req_cop = cop; bus0.l1d_req_size = size;
            bus0.l1d_req_addr = addr; bus0.l1d_req_wdata = wdata;
        end else begin
            bus1.l1d_req_val = v; bus1.l1d_req_cop = cop; bus1.l1d_req_size = size;
            bus1.l1d_req_addr = addr; bus1.l1d_req_wdata = wdata;
        end
    endtask

    // Called one step after an edge with the DUT idle; returns one step after
    // the edge that ends the ack cycle, so calls chain back-to-back.
    task automatic txn(input int d, input logic [2:0] cop, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input string tag);
        int n;
        int lat;
        lat = (d == 0) ? 2 : 1;
        drive(d, 1'b1, cop, size, addr, wdata);
        @(posedge clk); #1;
        n = 1;
        chk({tag, ".busy"}, 32'(get_busy(d)), 32'd1);
        while (!get_ack(d) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".lat"}, 32'(n), 32'(lat));
        chk({tag, ".rdata"}, get_rdata(d), exp_rd);
        drive(d, 1'b0, OP_RD, SZ_W, 32'h0, 32'h0);
        @(posedge clk); #1;
        chk({tag, ".idle"}, {30'd0, get_busy(d), get_ack(d)}, 32'd0);
    endtask

    initial begin
        drive(0, 1'b0, OP_RD, SZ_W, 32'h0, 32'h0);
        drive(1, 1'b0, OP_RD, SZ_W, 32'h0, 32'h0);
        rst0_n = 1'b0;
        rst1_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst0.ack",   32'(bus0.l1d_ack_ack), 32'd0);
        chk("rst0.rdata", bus0.l1d_ack_rdata, 32'h0);
        chk("rst0.flags", {29'd0, busy0, mis0, rng0}, 32'd0);
        chk("rst1.flags", {29'd0, busy1, mis1, rng1}, 32'd0);
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        @(posedge clk); #1;

        txn(0, OP_WR, SZ_W, 32'h10, 32'hDEADBEEF, 32'h0,        "wr_w10");
        txn(0, OP_RD, SZ_W, 32'h10, 32'h0,        32'hDEADBEEF, "rd_w10");
        txn(0, 3'b101, 3'b111, 32'h10, 32'h0,     32'hDEADBEEF, "rd_odd_codes");

        txn(0, OP_WR, SZ_B, 32'h20, 32'hAAAAAA11, 32'h0, "wr_b20");
        txn(0, OP_WR, SZ_B, 32'h21, 32'h55555522, 32'h0, "wr_b21");
        txn(0, OP_WR, SZ_B, 32'h22, 32'hFFFFFF33, 32'h0, "wr_b22");
        txn(0, OP_WR, SZ_B, 32'h23, 32'h12345644, 32'h0, "wr_b23");
        txn(0, OP_RD, SZ_H, 32'h22, 32'h0, 32'h00004433, "rd_h22");
        txn(0, OP_RD, SZ_B, 32'h21, 32'h0, 32'h00000022, "rd_b21");
        txn(0, OP_RD, SZ_B, 32'h23, 32'h0, 32'h00000044, "rd_b23");
        txn(0, OP_RD, SZ_W, 32'h20, 32'h0, 32'h44332211, "rd_w20");

        txn(0, OP_WR, SZ_H, 32'h22, 32'hFFFFABCD, 32'h0, "wr_h22");
        txn(0, OP_RD, SZ_W, 32'h20, 32'h0, 32'hABCD2211, "rd_w20_h");
        txn(0, OP_RD, SZ_H, 32'h20, 32'h0, 32'h00002211, "rd_h20");
        chk("no_err_yet", {30'd0, mis0, rng0}, 32'd0);

        txn(0, OP_WR, SZ_W, 32'h30, 32'h12345678, 32'h0, "wr_w30");
        txn(0, OP_RD, SZ_W, 32'h31, 32'h0,        32'h0, "rd_mis31");
        chk("mis_set", {30'd0, mis0, rng0}, 32'b10);
        txn(0, OP_WR, SZ_W, 32'h32, 32'hFFFFFFFF, 32'h0, "wr_mis32");
        txn(0, OP_WR, SZ_H, 32'h33, 32'hFFFFFFFF, 32'h0, "wr_mis33");
        txn(0, OP_RD, SZ_W, 32'h30, 32'h0, 32'h12345678, "rd_w30_kept");
        chk("mis_sticky", 32'(mis0), 32'd1);

        txn(0, OP_WR, SZ_W, 32'h0,    32'h0BADF00D, 32'h0, "wr_w0");
        txn(0, OP_WR, SZ_W, 32'h1000, 32'h11111111, 32'h0, "wr_rng");
        chk("rng_set", {30'd0, mis0, rng0}, 32'b11);
        txn(0, OP_RD, SZ_W, 32'h0,    32'h0, 32'h0BADF00D, "rd_w0_kept");
        txn(0, OP_RD, SZ_W, 32'h1004, 32'h0, 32'h0,        "rd_rng");
        chk("flags_sticky", {30'd0, mis0, rng0}, 32'b11);

        txn(1, OP_WR, SZ_W, 32'h40, 32'hCAFEF00D, 32'h0,        "l1_wr40");
        txn(1, OP_RD, SZ_W, 32'h40, 32'h0,        32'hCAFEF00D, "l1_rd40");

        drive(1, 1'b1, OP_WR, SZ_W, 32'h40, 32'h99999999);
        @(posedge clk); #1;
        chk("l1_rst.ack_before", 32'(bus1.l1d_ack_ack), 32'd1);
        rst1_n = 1'b0;
        #1;
        chk("l1_rst.ack_async", 32'(bus1.l1d_ack_ack), 32'd0);
        chk("l1_rst.busy", 32'(busy1), 32'd0);
        drive(1, 1'b0, OP_RD, SZ_W, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst1_n = 1'b1;
        @(posedge clk); #1;
        chk("l1_rst.no_ack", {30'd0, busy1, bus1.l1d_ack_ack}, 32'd0);
        txn(1, OP_RD, SZ_W, 32'h40, 32'h0, 32'hCAFEF00D, "l1_rd40_kept");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout: observed no finish, required finish before 200000");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

endmodule
